eu_dispatcher: RTL and testbench

EU_DISPATCHER -- requirements
Module: eu_dispatcher

---
 rtl/eu_dispatcher.sv | 209 ++++++++++++++++++++
 tb/tb_eu_dispatcher.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eu_dispatcher.sv
// -----------------------------------------------------------------------------
// eu_dispatcher
//
// Routes a single upstream instruction stream into one FIFO per execution
// unit (EU 0 = IU, 1 = LSU, 2 = BRU by default). Each EU drains its own
// queue independently. Instructions aimed at a non-existent EU are accepted
// and dropped. The drop raises a one-cycle illegal pulse and bumps a
// saturating counter.
//
// Optional feature (compile-time macro):
//   EU_DISPATCHER_SUBTYPE_CHECK_EN
//     When defined, an instruction whose subtype is >= EuNumSubtypes[eu] is
//     also treated as illegal. When undefined, the subtype is carried as
//     opaque data and EuNumSubtypes is only sanity-checked at elaboration.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_ni          asynchronous active-low reset
//   flush_i         synchronous clear of every queue; blocks acceptance
//   inst_valid_i    upstream instruction valid
//   inst_ready_o    instruction accepted when high with inst_valid_i
//   inst_eu_i       target EU index
//   inst_subtype_i  subtype within target EU
//   inst_payload_i  opaque payload
//   eu_valid_o      per-EU head valid
//   eu_ready_i      per-EU pop request
//   eu_subtype_o    per-EU head subtype, EU k at slice k
//   eu_payload_o    per-EU head payload, EU k at slice k
//   illegal_o       pulse, cycle after an illegal instruction is accepted
//   illegal_cnt_o   saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module eu_dispatcher #(
    parameter int NumEus       = 3,
    parameter int SubtypeWidth = 6,
    parameter int PayloadWidth = 32,
    parameter int FifoDepth    = 2,
    parameter logic [NumEus-1:0][SubtypeWidth:0] EuNumSubtypes =
        {(SubtypeWidth+1)'(4), (SubtypeWidth+1)'(6), (SubtypeWidth+1)'(15)},
    parameter int CntWidth     = 16,
    localparam int EuIdxWidth  = ($clog2(NumEus + 1) > 1) ? $clog2(NumEus + 1) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           inst_valid_i,
    output logic                           inst_ready_o,
    input  logic [EuIdxWidth-1:0]          inst_eu_i,
    input  logic [SubtypeWidth-1:0]        inst_subtype_i,
    input  logic [PayloadWidth-1:0]        inst_payload_i,
    output logic [NumEus-1:0]              eu_valid_o,
    input  logic [NumEus-1:0]              eu_ready_i,
    output logic [NumEus*SubtypeWidth-1:0] eu_subtype_o,
    output logic [NumEus*PayloadWidth-1:0] eu_payload_o,
    output logic                           illegal_o,
    output logic [CntWidth-1:0]            illegal_cnt_o
);

    localparam int PtrWidth   = $clog2(FifoDepth);
    localparam int CountWidth = PtrWidth + 1;
    localparam logic [CountWidth-1:0] DepthCount = CountWidth'(FifoDepth);
    localparam logic [EuIdxWidth-1:0] NumEusIdx  = EuIdxWidth'(NumEus);

    typedef struct packed {
        logic [SubtypeWidth-1:0] subtype;
        logic [PayloadWidth-1:0] payload;
    } entry_t;

    // Elaboration-time sanity checks on the configuration.
    if ((FifoDepth < 2) || ((1 << PtrWidth) != FifoDepth)) begin : g_bad_depth
        $error("eu_dispatcher: FifoDepth must be a power of two >= 2");
    end
    for (genvar k = 0; k < NumEus; k++) begin : g_cfg_check
        if (int'(EuNumSubtypes[k]) > (1 << SubtypeWidth)) begin : g_bad_subtypes
            $error("eu_dispatcher: EuNumSubtypes entry exceeds subtype range");
        end
    end

    // ------------------------------------------------------------------
    // Legality and acceptance
    // ------------------------------------------------------------------
    logic [NumEus-1:0] q_full;
    logic [NumEus-1:0] push;
    logic              eu_in_range;
    logic              inst_illegal;
    logic              target_full;
    logic              accept;
    entry_t            wr_entry;

    assign eu_in_range = (inst_eu_i < NumEusIdx);

    // Fullness of the addressed queue. An out-of-range index selects nothing
    // and reads as not-full; it is illegal anyway and never pushes.
    // NOTE: every variable written in an always_comb gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        target_full = 1'b0;
        for (int k = 0; k < NumEus; k++) begin
            if (inst_eu_i == EuIdxWidth'(k)) begin
                target_full = q_full[k];
            end
        end
    end

`ifdef EU_DISPATCHER_SUBTYPE_CHECK_EN
    logic subtype_ok;

    always_comb begin
        subtype_ok = 1'b1;
        for (int k = 0; k < NumEus; k++) begin
            if (inst_eu_i == EuIdxWidth'(k)) begin
                subtype_ok = ({1'b0, inst_subtype_i} < EuNumSubtypes[k]);
            end
        end
    end

    assign inst_illegal = !eu_in_range || !subtype_ok;
`else
    assign inst_illegal = !eu_in_range;
`endif

    // Readiness depends on the stored count only, never on eu_ready_i, so a
    // full queue refuses a push even when it is being popped that cycle.
    assign inst_ready_o = !flush_i && (inst_illegal || !target_full);
    assign accept       = inst_valid_i && inst_ready_o;

    assign wr_entry.subtype = inst_subtype_i;
    assign wr_entry.payload = inst_payload_i;

    // ------------------------------------------------------------------
    // Per-EU queues
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NumEus; k++) begin : g_queue
        entry_t                mem [FifoDepth];
        logic [PtrWidth-1:0]   rd_ptr;
        logic [PtrWidth-1:0]   wr_ptr;
        logic [CountWidth-1:0] count;
        logic                  pop;

        assign push[k]   = accept && !inst_illegal && (inst_eu_i == EuIdxWidth'(k));
        assign pop       = (count != '0) && eu_ready_i[k];
        assign q_full[k] = (count == DepthCount);

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else if (flush_i) begin
                // Flush wins over any push or pop in the same cycle.
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                // Pointers are PtrWidth bits and FifoDepth is a power of two,
                // so the natural overflow is the modulo-FifoDepth wrap.
                if (push[k]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                unique case ({push[k], pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // NOTE: the storage array has no reset; an entry is only observed
        // after it has been written, because eu_valid_o comes from count.
        always_ff @(posedge clk_i) begin
            if (push[k]) begin
                mem[wr_ptr] <= wr_entry;
            end
        end

        assign eu_valid_o[k]                                = (count != '0);
        assign eu_subtype_o[k*SubtypeWidth +: SubtypeWidth] = mem[rd_ptr].subtype;
        assign eu_payload_o[k*PayloadWidth +: PayloadWidth] = mem[rd_ptr].payload;
    end

    // ------------------------------------------------------------------
    // Illegal-instruction reporting (not affected by flush)
    // ------------------------------------------------------------------
    logic                illegal_q;
    logic [CntWidth-1:0] illegal_cnt_q;
    logic                illegal_accept;

    assign illegal_accept = accept && inst_illegal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            illegal_q <= illegal_accept;
            if (illegal_accept && (illegal_cnt_q != '1)) begin
                illegal_cnt_q <= illegal_cnt_q + 1'b1;
            end
        end
    end

    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_eu_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_eu_dispatcher
//
// Self-checking bench for eu_dispatcher. A queue-based model of the
// dispatcher is compared against the DUT on every falling clock edge, and
// directed sequences add literal expectations. A second instance with a
// 2-bit counter exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_eu_dispatcher;

    localparam int NumEus = 3;
    localparam int SW     = 6;
    localparam int PW     = 32;
    localparam int Depth  = 2;
    localparam int CntW   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              inst_valid = 1'b0;
    logic              inst_ready;
    logic [1:0]        inst_eu = '0;
    logic [SW-1:0]     inst_subtype = '0;
    logic [PW-1:0]     inst_payload = '0;
    logic [NumEus-1:0] eu_valid;
    logic [NumEus-1:0] eu_ready = '0;
    logic [NumEus*SW-1:0] eu_subtype;
    logic [NumEus*PW-1:0] eu_payload;
    logic              illegal;
    logic [CntW-1:0]   illegal_cnt;

    logic              sat_valid = 1'b0;
    logic              sat_ready;
    logic [NumEus-1:0] sat_eu_valid;
    logic [NumEus*SW-1:0] sat_eu_subtype;
    logic [NumEus*PW-1:0] sat_eu_payload;
    logic              sat_illegal;
    logic [1:0]        sat_cnt;

    always #5 clk = ~clk;

    eu_dispatcher dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .inst_valid_i   (inst_valid),
        .inst_ready_o   (inst_ready),
        .inst_eu_i      (inst_eu),
        .inst_subtype_i (inst_subtype),
        .inst_payload_i (inst_payload),
        .eu_valid_o     (eu_valid),
        .eu_ready_i     (eu_ready),
        .eu_subtype_o   (eu_subtype),
        .eu_payload_o   (eu_payload),
        .illegal_o      (illegal),
        .illegal_cnt_o  (illegal_cnt)
    );

    eu_dispatcher #(.CntWidth(2)) dut_sat (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (1'b0),
        .inst_valid_i   (sat_valid),
        .inst_ready_o   (sat_ready),
        .inst_eu_i      (2'd3),
        .inst_subtype_i (6'd0),
        .inst_payload_i (32'd0),
        .eu_valid_o     (sat_eu_valid),
        .eu_ready_i     (3'b000),
        .eu_subtype_o   (sat_eu_subtype),
        .eu_payload_o   (sat_eu_payload),
        .illegal_o      (sat_illegal),
        .illegal_cnt_o  (sat_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one queue per EU plus the illegal bookkeeping.
    // ------------------------------------------------------------------
    logic [SW+PW-1:0] mq [NumEus][$];
    bit               m_illegal = 1'b0;
    int unsigned      m_cnt = 0;
    bit               cmp_en = 1'b0;

    function automatic bit m_is_illegal(input logic [1:0] eu, input logic [SW-1:0] st);
        int lim [NumEus] = '{15, 6, 4};
        if (int'(eu) >= NumEus) return 1'b1;
`ifdef EU_DISPATCHER_SUBTYPE_CHECK_EN
        if (int'(st) >= lim[eu]) return 1'b1;
`else
        if (st === 'x) return 1'b0;
        if (lim[0] < 0) return 1'b0;
`endif
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (m_is_illegal(inst_eu, inst_subtype)) return 1'b1;
        return mq[inst_eu].size() < Depth;
    endfunction

    always @(negedge rst_n) begin
        for (int k = 0; k < NumEus; k++) mq[k].delete();
        m_illegal = 1'b0;
        m_cnt     = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) begin
                for (int k = 0; k < NumEus; k++) mq[k].delete();
                m_illegal = 1'b0;
            end else begin
                bit acc;
                bit ill;
                bit do_pop [NumEus];
                acc = inst_valid && m_ready();
                ill = m_is_illegal(inst_eu, inst_subtype);
                for (int k = 0; k < NumEus; k++) do_pop[k] = (mq[k].size() > 0) && eu_ready[k];
                for (int k = 0; k < NumEus; k++) if (do_pop[k]) void'(mq[k].pop_front());
                if (acc && !ill) mq[inst_eu].push_back({inst_subtype, inst_payload});
                m_illegal = acc && ill;
                if (acc && ill && m_cnt < (2**CntW - 1)) m_cnt++;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < NumEus; k++) begin
                bit exp_v;
                logic [SW+PW-1:0] e;
                exp_v = (mq[k].size() != 0);
                check($sformatf("eu_valid[%0d]", k), 64'(eu_valid[k]), 64'(exp_v));
                if (exp_v) begin
                    e = mq[k][0];
                    check($sformatf("eu_subtype[%0d]", k), 64'(eu_subtype[k*SW +: SW]), 64'(e[SW+PW-1:PW]));
                    check($sformatf("eu_payload[%0d]", k), 64'(eu_payload[k*PW +: PW]), 64'(e[PW-1:0]));
                end
            end
            check("illegal_o", 64'(illegal), 64'(m_illegal));
            check("illegal_cnt_o", 64'(illegal_cnt), 64'(m_cnt));
            check("inst_ready_o", 64'(inst_ready), 64'(m_ready()));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [1:0] eu, input logic [SW-1:0] st,
                         input logic [PW-1:0] pay, input logic [NumEus-1:0] rdy, input logic fl);
        inst_valid   = v;
        inst_eu      = eu;
        inst_subtype = st;
        inst_payload = pay;
        eu_ready     = rdy;
        flush        = fl;
    endtask

    initial begin
        int exp_cnt;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        cmp_en = 1'b1;
        check("reset eu_valid", 64'(eu_valid), 64'h0);
        check("reset illegal_cnt", 64'(illegal_cnt), 64'h0);
        check("reset illegal", 64'(illegal), 64'h0);
        check("reset inst_ready", 64'(inst_ready), 64'h1);
        rst_n = 1'b1;
        step();

        // Single push, latency one
        drive(1, 2'd0, 6'h05, 32'hCAFE, 3'b000, 0);
        check("push ready", 64'(inst_ready), 64'h1);
        check("no fall-through", 64'(eu_valid), 64'h0);
        step();
        inst_valid = 0;
        check("first eu_valid", 64'(eu_valid), 64'b001);
        check("first subtype", 64'(eu_subtype[SW-1:0]), 64'h05);
        check("first payload", 64'(eu_payload[PW-1:0]), 64'hCAFE);
        eu_ready = 3'b111;
        step();
        eu_ready = 3'b000;
        check("drained", 64'(eu_valid), 64'h0);

        // Fill LSU queue past depth
        drive(1, 2'd1, 6'h01, 32'h1111, 3'b000, 0);
        step();
        inst_payload = 32'h2222;
        step();
        inst_payload = 32'h3333;
        check("full refuses", 64'(inst_ready), 64'h0);
        step();
        check("lsu head first", 64'(eu_payload[2*PW-1:PW]), 64'h1111);
        eu_ready = 3'b010;
        step();
        check("lsu head second", 64'(eu_payload[2*PW-1:PW]), 64'h2222);
        check("ready after pop", 64'(inst_ready), 64'h1);
        step();
        inst_valid = 0;
        check("lsu head third", 64'(eu_payload[2*PW-1:PW]), 64'h3333);
        step();
        eu_ready = 3'b000;
        check("lsu empty", 64'(eu_valid), 64'h0);

        // Illegal EU index
        drive(1, 2'd3, 6'h00, 32'hDEAD, 3'b000, 0);
        check("illegal ready", 64'(inst_ready), 64'h1);
        step();
        inst_valid = 0;
        check("illegal pulse", 64'(illegal), 64'h1);
        check("illegal cnt 1", 64'(illegal_cnt), 64'h1);
        check("illegal no queue", 64'(eu_valid), 64'h0);
        step();
        check("illegal pulse ends", 64'(illegal), 64'h0);

        // Subtype legality on BRU
        drive(1, 2'd2, 6'h04, 32'h4444, 3'b000, 0);
        step();
        drive(1, 2'd2, 6'h03, 32'h5555, 3'b000, 0);
        step();
        inst_valid = 0;
`ifdef EU_DISPATCHER_SUBTYPE_CHECK_EN
        exp_cnt = 2;
        check("bru head", 64'(eu_payload[3*PW-1:2*PW]), 64'h5555);
`else
        exp_cnt = 1;
        check("bru head", 64'(eu_payload[3*PW-1:2*PW]), 64'h4444);
`endif
        check("subtype cnt", 64'(illegal_cnt), 64'(exp_cnt));
        eu_ready = 3'b111;
        step();
        step();
        eu_ready = 3'b000;

        // Simultaneous push and pop on one-entry queue
        drive(1, 2'd0, 6'h01, 32'hA1, 3'b000, 0);
        step();
        drive(1, 2'd0, 6'h02, 32'hA2, 3'b001, 0);
        step();
        drive(0, 2'd0, 6'h00, 32'h0, 3'b000, 0);
        check("push+pop valid", 64'(eu_valid), 64'b001);
        check("push+pop head", 64'(eu_payload[PW-1:0]), 64'hA2);
        eu_ready = 3'b001;
        step();
        eu_ready = 3'b000;
        check("push+pop count 1", 64'(eu_valid), 64'h0);

        // Flush with concurrent push
        drive(1, 2'd0, 6'h01, 32'hB0, 3'b000, 0);
        step();
        drive(1, 2'd1, 6'h01, 32'hB1, 3'b000, 0);
        step();
        drive(1, 2'd2, 6'h00, 32'hB2, 3'b000, 1);
        #1;
        check("flush ready low", 64'(inst_ready), 64'h0);
        step();
        drive(0, 2'd0, 6'h00, 32'h0, 3'b000, 0);
        check("flush empties", 64'(eu_valid), 64'h0);
        check("flush keeps cnt", 64'(illegal_cnt), 64'(exp_cnt));

        // Randomized traffic with a mid-run asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)),
                  $urandom, 3'($urandom), ($urandom_range(0, 31) == 0));
            step();
        end
        drive(0, 2'd0, 6'h00, 32'h0, 3'b000, 0);
        step();

        // Counter saturation on the 2-bit instance
        sat_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("sat cnt %0d", i), 64'(sat_cnt), 64'((i < 3) ? i : 3));
        end
        check("sat pulse", 64'(sat_illegal), 64'h1);
        sat_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
